// File: rtl/bus_ctrl_pkg.sv
// Shared types and helpers for the coherence bus arbiter and the bus controller side.
package bus_ctrl_pkg;

  localparam int CPUS          = 2;
  localparam int CPU_ID_LENGTH = (CPUS > 1) ? $clog2(CPUS) : 1;

  typedef logic [CPUS-1:0]          cpus_bitvec_t;
  typedef logic [CPU_ID_LENGTH-1:0] cpuid_t;

  typedef enum logic [1:0] {
    REQ_R     = 2'd0,
    REQ_RX    = 2'd1,
    REQ_EVICT = 2'd2,
    REQ_INV   = 2'd3
  } bus_req_t;

  typedef logic [1:0] arb_state_t;
  localparam arb_state_t ARB_IDLE    = 2'd0;
  localparam arb_state_t ARB_GRANT   = 2'd1;
  localparam arb_state_t ARB_BUSY    = 2'd2;
  localparam arb_state_t ARB_RELEASE = 2'd3;

  // Eviction outranks everything so dirty data leaves before the line is re-requested.
  function automatic bus_req_t classify_req(input logic dren, input logic dwen, input logic ccw);
    if (dwen)
      return REQ_EVICT;
    if (dren && ccw)
      return REQ_RX;
    if (ccw)
      return REQ_INV;
    return REQ_R;
  endfunction

  function automatic cpuid_t next_cpu(input cpuid_t id);
    return (id == cpuid_t'(CPUS - 1)) ? '0 : id + cpuid_t'(1);
  endfunction

endpackage

// File: rtl/coherence_bus_arbiter_if.sv
// Request/grant bundle between the L1 caches, the arbiter and the bus controller.
interface coherence_bus_arbiter_if;
  import bus_ctrl_pkg::*;

  cpus_bitvec_t dREN;
  cpus_bitvec_t dWEN;
  cpus_bitvec_t ccwrite;
  logic         gnt_ready;
  logic         xfer_done;
  logic         gnt_valid;
  cpuid_t       gnt_id;
  cpus_bitvec_t gnt_onehot;
  bus_req_t     gnt_type;
  logic         arb_busy;
  logic         arb_timeout;

  modport master (
    input  dREN, dWEN, ccwrite, gnt_ready, xfer_done,
    output gnt_valid, gnt_id, gnt_onehot, gnt_type, arb_busy, arb_timeout
  );

  modport slave (
    output dREN, dWEN, ccwrite, gnt_ready, xfer_done,
    input  gnt_valid, gnt_id, gnt_onehot, gnt_type, arb_busy, arb_timeout
  );

endinterface

// File: rtl/coherence_bus_arbiter_rr_picker.sv
// Combinational round-robin pick: first set request at or after ptr_i, wrapping at N-1.
module rr_picker #(
  parameter  int N    = 2,
  localparam int IDXW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [IDXW-1:0] ptr_i,
  output logic            found_o,
  output logic [IDXW-1:0] idx_o
);

  always_comb begin
    logic [IDXW-1:0] j;
    found_o = 1'b0;
    idx_o   = '0;
    j       = '0;
    // Scan farthest offset first so the closest requester to ptr_i overwrites last.
    for (int k = N - 1; k >= 0; k--) begin
      j = IDXW'((int'(ptr_i) + k) % N);
      if (req_i[j]) begin
        found_o = 1'b1;
        idx_o   = j;
      end
    end
  end

endmodule

// File: rtl/coherence_bus_arbiter.sv
// Round-robin grant arbiter feeding the coherence bus controller.
// Optional watchdog on the BUSY phase is built when BUS_ARB_WATCHDOG_EN is defined.
module coherence_bus_arbiter
  import bus_ctrl_pkg::*;
`ifdef BUS_ARB_WATCHDOG_EN
#(
  parameter int TIMEOUT = 1024
)
`endif
(
  input logic                     CLK,
  input logic                     nRST,
  coherence_bus_arbiter_if.master bus
);

  cpus_bitvec_t req;
  bus_req_t     req_type [CPUS];
  logic         pick_found;
  cpuid_t       pick_idx;

  for (genvar gi = 0; gi < CPUS; gi++) begin : g_req
    assign req[gi]      = bus.dREN[gi] | bus.dWEN[gi] | bus.ccwrite[gi];
    assign req_type[gi] = classify_req(bus.dREN[gi], bus.dWEN[gi], bus.ccwrite[gi]);
  end

  arb_state_t   state_q, state_d;
  cpuid_t       rr_ptr_q, rr_ptr_d;
  cpuid_t       gnt_id_q, gnt_id_d;
  bus_req_t     gnt_type_q, gnt_type_d;
  logic         gnt_valid_q, gnt_valid_d;
  cpus_bitvec_t gnt_onehot_q, gnt_onehot_d;
  logic         arb_busy_q, arb_busy_d;

`ifdef BUS_ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            timeout_q, timeout_d;
`endif

  rr_picker #(.N(CPUS)) u_picker (
    .req_i   (req),
    .ptr_i   (rr_ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    gnt_id_d   = gnt_id_q;
    gnt_type_d = gnt_type_q;
`ifdef BUS_ARB_WATCHDOG_EN
    wd_cnt_d   = wd_cnt_q;
    timeout_d  = timeout_q;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          gnt_id_d   = pick_idx;
          gnt_type_d = req_type[pick_idx];
          state_d    = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        // Accept beats a simultaneous withdrawal; the pointer only moves on accept.
        if (bus.gnt_ready) begin
          state_d  = ARB_BUSY;
          rr_ptr_d = next_cpu(gnt_id_q);
`ifdef BUS_ARB_WATCHDOG_EN
          wd_cnt_d = '0;
`endif
        end else if (!req[gnt_id_q]) begin
          state_d = ARB_IDLE;
        end
      end
      ARB_BUSY: begin
        if (bus.xfer_done) begin
          state_d = ARB_RELEASE;
        end
`ifdef BUS_ARB_WATCHDOG_EN
        else if (wd_cnt_q == WD_W'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = ARB_RELEASE;
        end else begin
          wd_cnt_d = wd_cnt_q + WD_W'(1);
        end
`endif
      end
      ARB_RELEASE: state_d = ARB_IDLE;
      default:     state_d = ARB_IDLE;
    endcase

    gnt_valid_d  = (state_d == ARB_GRANT);
    arb_busy_d   = (state_d == ARB_BUSY) || (state_d == ARB_RELEASE);
    gnt_onehot_d = '0;
    if (gnt_valid_d)
      gnt_onehot_d[gnt_id_d] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q      <= ARB_IDLE;
      rr_ptr_q     <= '0;
      gnt_id_q     <= '0;
      gnt_type_q   <= REQ_R;
      gnt_valid_q  <= 1'b0;
      gnt_onehot_q <= '0;
      arb_busy_q   <= 1'b0;
`ifdef BUS_ARB_WATCHDOG_EN
      wd_cnt_q     <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      gnt_id_q     <= gnt_id_d;
      gnt_type_q   <= gnt_type_d;
      gnt_valid_q  <= gnt_valid_d;
      gnt_onehot_q <= gnt_onehot_d;
      arb_busy_q   <= arb_busy_d;
`ifdef BUS_ARB_WATCHDOG_EN
      wd_cnt_q     <= wd_cnt_d;
      timeout_q    <= timeout_d;
`endif
    end
  end

  assign bus.gnt_valid  = gnt_valid_q;
  assign bus.gnt_id     = gnt_id_q;
  assign bus.gnt_onehot = gnt_onehot_q;
  assign bus.gnt_type   = gnt_type_q;
  assign bus.arb_busy   = arb_busy_q;
`ifdef BUS_ARB_WATCHDOG_EN
  assign bus.arb_timeout = timeout_q;
`else
  assign bus.arb_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_coherence_bus_arbiter.sv
// Randomized and directed bench for coherence_bus_arbiter against a transaction-level model.
// Define BUS_ARB_WATCHDOG_EN to build the DUT with an 8-cycle watchdog.
module tb_coherence_bus_arbiter;
  import bus_ctrl_pkg::*;

`ifdef BUS_ARB_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
  localparam int TO    = 8;
`else
  localparam bit WD_EN = 1'b0;
  localparam int TO    = 0;
`endif

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  coherence_bus_arbiter_if bif ();

`ifdef BUS_ARB_WATCHDOG_EN
  coherence_bus_arbiter #(.TIMEOUT(TO)) dut (.CLK(CLK), .nRST(nRST), .bus(bif));
`else
  coherence_bus_arbiter dut (.CLK(CLK), .nRST(nRST), .bus(bif));
`endif

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else
      n_pass++;
  endtask

  // Reference model: who owns the bus and which phase of a transaction we are in.
  typedef enum {P_IDLE, P_OFFER, P_OWN, P_COOL} phase_e;
  phase_e   m_phase;
  int       m_ptr, m_id, m_busy;
  bus_req_t m_type;
  bit       m_to;

  function automatic bit wants(input cpus_bitvec_t r, input cpus_bitvec_t w,
                               input cpus_bitvec_t c, input int i);
    return r[i] || w[i] || c[i];
  endfunction

  function automatic bus_req_t ref_type(input bit r, input bit w, input bit c);
    if (w) return REQ_EVICT;
    if (r) return c ? REQ_RX : REQ_R;
    return REQ_INV;
  endfunction

  task automatic model_step(input bit rst_n, input cpus_bitvec_t r, input cpus_bitvec_t w,
                            input cpus_bitvec_t c, input bit rdy, input bit done);
    if (!rst_n) begin
      m_phase = P_IDLE; m_ptr = 0; m_id = 0; m_busy = 0; m_type = REQ_R; m_to = 0;
      return;
    end
    case (m_phase)
      P_IDLE: begin
        for (int k = 0; k < CPUS; k++) begin
          int cand;
          cand = (m_ptr + k) % CPUS;
          if (wants(r, w, c, cand)) begin
            m_id    = cand;
            m_type  = ref_type(r[cand], w[cand], c[cand]);
            m_phase = P_OFFER;
            break;
          end
        end
      end
      P_OFFER: begin
        if (rdy) begin
          m_phase = P_OWN; m_ptr = (m_id + 1) % CPUS; m_busy = 0;
        end else if (!wants(r, w, c, m_id)) begin
          m_phase = P_IDLE;
        end
      end
      P_OWN: begin
        m_busy++;
        if (done) m_phase = P_COOL;
        else if (WD_EN && m_busy == TO) begin m_to = 1; m_phase = P_COOL; end
      end
      P_COOL: m_phase = P_IDLE;
      default: m_phase = P_IDLE;
    endcase
  endtask

  task automatic cyc(input cpus_bitvec_t r, input cpus_bitvec_t w, input cpus_bitvec_t c,
                     input bit rdy, input bit done);
    logic [31:0] exp_oh;
    bif.dREN = r; bif.dWEN = w; bif.ccwrite = c;
    bif.gnt_ready = rdy; bif.xfer_done = done;
    @(posedge CLK);
    model_step(nRST, r, w, c, rdy, done);
    #1;
    exp_oh = (m_phase == P_OFFER) ? (32'd1 << m_id) : 32'd0;
    check_val("gnt_valid", 32'(bif.gnt_valid), 32'(m_phase == P_OFFER));
    check_val("gnt_id", 32'(bif.gnt_id), m_id);
    check_val("gnt_onehot", 32'(bif.gnt_onehot), exp_oh);
    check_val("gnt_type", 32'(bif.gnt_type), 32'(m_type));
    check_val("arb_busy", 32'(bif.arb_busy), 32'(m_phase == P_OWN || m_phase == P_COOL));
    check_val("arb_timeout", 32'(bif.arb_timeout), 32'(m_to));
  endtask

  task automatic do_reset(input int n);
    nRST = 1'b0;
    repeat (n) cyc(2'b11, 2'b00, 2'b00, 1'b0, 1'b0);
    nRST = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int q[$];
    cpus_bitvec_t rr, rw, rc;
    nRST = 1'b0;
    bif.dREN = '0; bif.dWEN = '0; bif.ccwrite = '0; bif.gnt_ready = 1'b0; bif.xfer_done = 1'b0;
    @(posedge CLK); #1;

    // Reset held with requests present
    do_reset(3);
    check_val("rst_valid", 32'(bif.gnt_valid), 32'd0);
    check_val("rst_busy", 32'(bif.arb_busy), 32'd0);

    // Single requester, full transaction
    cyc(2'b10, 2'b00, 2'b00, 1'b0, 1'b0);
    check_val("t2_valid", 32'(bif.gnt_valid), 32'd1);
    check_val("t2_id", 32'(bif.gnt_id), 32'd1);
    check_val("t2_type", 32'(bif.gnt_type), 32'(REQ_R));
    check_val("t2_onehot", 32'(bif.gnt_onehot), 32'b10);
    cyc(2'b10, 2'b00, 2'b00, 1'b1, 1'b0);
    check_val("t2_busy", 32'(bif.arb_busy), 32'd1);
    cyc(2'b10, 2'b00, 2'b00, 1'b0, 1'b1);
    check_val("t2_release", 32'(bif.arb_busy), 32'd1);
    cyc(2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    check_val("t2_idle", 32'(bif.arb_busy), 32'd0);

    // Fairness with both CPUs requesting continuously
    do_reset(2);
    for (int t = 0; t < 40 && q.size() < 4; t++) begin
      cyc(2'b11, 2'b00, 2'b00, 1'b1, 1'b1);
      if (bif.gnt_valid) q.push_back(int'(bif.gnt_id));
    end
    for (int i = 0; i < 4; i++)
      check_val($sformatf("fair_order%0d", i), (i < q.size()) ? q[i] : 32'hFF, i % 2);

    // Type priority
    do_reset(1);
    cyc(2'b01, 2'b01, 2'b01, 1'b0, 1'b0);
    check_val("t4_evict", 32'(bif.gnt_type), 32'(REQ_EVICT));
    do_reset(1);
    cyc(2'b00, 2'b00, 2'b01, 1'b0, 1'b0);
    check_val("t4_inv", 32'(bif.gnt_type), 32'(REQ_INV));
    do_reset(1);
    cyc(2'b01, 2'b00, 2'b01, 1'b0, 1'b0);
    check_val("t4_rx", 32'(bif.gnt_type), 32'(REQ_RX));

    // Withdrawal before accept leaves the pointer alone
    do_reset(1);
    cyc(2'b01, 2'b00, 2'b00, 1'b0, 1'b0);
    cyc(2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    check_val("t5_withdrawn", 32'(bif.gnt_valid), 32'd0);
    cyc(2'b10, 2'b00, 2'b00, 1'b0, 1'b0);
    check_val("t5_cpu1_id", 32'(bif.gnt_id), 32'd1);
    do_reset(1);
    cyc(2'b01, 2'b00, 2'b00, 1'b0, 1'b0);
    cyc(2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    cyc(2'b11, 2'b00, 2'b00, 1'b0, 1'b0);
    check_val("t5_ptr_kept", 32'(bif.gnt_id), 32'd0);
    // Accept and withdrawal in the same cycle: accept wins
    cyc(2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
    check_val("t5_accept_wins", 32'(bif.arb_busy), 32'd1);
    cyc(2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
    cyc(2'b00, 2'b00, 2'b00, 1'b0, 1'b0);

    // Watchdog: owner never completes
    do_reset(1);
    cyc(2'b01, 2'b00, 2'b00, 1'b0, 1'b0);
    cyc(2'b01, 2'b00, 2'b00, 1'b1, 1'b0);
    repeat (12) cyc(2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    check_val("t6_flag", 32'(bif.arb_timeout), 32'(WD_EN));
    check_val("t6_busy", 32'(bif.arb_busy), 32'(!WD_EN));
    cyc(2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
    cyc(2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    check_val("t6_sticky", 32'(bif.arb_timeout), 32'(WD_EN));
    do_reset(1);
    check_val("t6_cleared", 32'(bif.arb_timeout), 32'd0);

    // Randomized traffic with occasional mid-transaction resets
    rr = '0; rw = '0; rc = '0;
    for (int t = 0; t < 800; t++) begin
      for (int i = 0; i < CPUS; i++) begin
        if ($urandom_range(3) == 0) begin
          rr[i] = 1'($urandom_range(1));
          rw[i] = ($urandom_range(3) == 0);
          rc[i] = 1'($urandom_range(1));
        end
      end
      if ($urandom_range(150) == 0) do_reset(1);
      cyc(rr, rw, rc, 1'($urandom_range(1)), ($urandom_range(2) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
